pll_lock_monitor: RTL and testbench

//  Synthesizable, multi-channel supervisor for PLL lock outputs (clk_generate and successors).
//  - Synchronises each asynchronous lock_in bit.
//  - Qualifies lock with a stability window.
//  - Flags lock timeout and loss-of-lock, and keeps saturating per-channel error counts.
//  - Sits beside the PLL instances and feeds system reset release and status registers.

---
 rtl/pll_mon_pkg.sv | 20 ++
 rtl/pll_lock_ch.sv | 148 ++++++++++++++
 rtl/pll_lock_monitor.sv | 51 +++++
 tb/tb_pll_lock_monitor.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_mon_pkg                                                        |
// | Shared state encoding for the PLL lock monitor channels.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pll_mon_pkg;

  localparam int C_STATE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_lock_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_lock_ch                                                        |
// | One PLL lock channel: synchroniser, qualify FSM, sticky flags and  |
// | a saturating event counter.                                        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pll_lock_ch #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int ERR_CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_lock,
  input  logic                 i_start,
  input  logic                 i_clr_err,
  output logic                 o_locked,
  output logic                 o_timeout_err,
  output logic                 o_unlock_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  import pll_mon_pkg::*;

  localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [TCNT_W-1:0]    C_TCNT_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [SCNT_W-1:0]    C_SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [ERR_CNT_W-1:0] C_CNT_ONE   = ERR_CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [TCNT_W-1:0]      r_tcnt;
  logic [SCNT_W-1:0]      r_scnt;
  logic                   r_locked;
  logic                   r_timeout_err;
  logic                   r_unlock_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic w_lock_s;
  logic w_timeout;
  logic w_ev_to;
  logic w_ev_ul;
  logic w_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_lock};
    end
  end

  assign w_lock_s  = r_sync[SYNC_STAGES-1];
  assign w_timeout = (r_tcnt == C_TCNT_LAST);

  // A start in the same cycle pre-empts any FAULT entry, so no event is raised then.
  assign w_ev_to = !i_start && w_timeout &&
                   ((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE));
  assign w_ev_ul = !i_start && (r_state == ST_LOCKED) && !w_lock_s;
  assign w_ev    = w_ev_to || w_ev_ul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tcnt   <= '0;
      r_scnt   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= 1'b0;
      if (i_start) begin
        r_state <= ST_WAIT_LOCK;
        r_tcnt  <= '0;
        r_scnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_WAIT_LOCK: begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
            if (w_timeout) begin
              r_state <= ST_FAULT;
            end else if (w_lock_s) begin
              r_state <= ST_STABLE;
              r_scnt  <= '0;
            end
          end
          ST_STABLE: begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
            if (w_timeout) begin
              r_state <= ST_FAULT;
            end else if (!w_lock_s) begin
              r_state <= ST_WAIT_LOCK;
            end else if (r_scnt == C_SCNT_LAST) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_scnt <= r_scnt + SCNT_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!w_lock_s) begin
              r_state <= ST_FAULT;
            end else begin
              r_locked <= 1'b1;
            end
          end
          ST_FAULT: begin
            r_state <= ST_FAULT;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // A clear coinciding with an event leaves only that event recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_unlock_err  <= 1'b0;
      r_err_cnt     <= '0;
    end else if (i_clr_err) begin
      r_timeout_err <= w_ev_to;
      r_unlock_err  <= w_ev_ul;
      r_err_cnt     <= w_ev ? C_CNT_ONE : '0;
    end else begin
      r_timeout_err <= r_timeout_err || w_ev_to;
      r_unlock_err  <= r_unlock_err || w_ev_ul;
      if (w_ev && (r_err_cnt != C_CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + C_CNT_ONE;
      end
    end
  end

  assign o_locked      = r_locked;
  assign o_timeout_err = r_timeout_err;
  assign o_unlock_err  = r_unlock_err;
  assign o_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/pll_lock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_lock_monitor                                                   |
// | Multi-channel PLL lock supervisor with summary status outputs.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pll_lock_monitor #(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int ERR_CNT_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           lock_in,
  input  logic                        start,
  input  logic                        clr_err,
  output logic [NUM_CH-1:0]           locked,
  output logic                        all_locked,
  output logic [NUM_CH-1:0]           timeout_err,
  output logic [NUM_CH-1:0]           unlock_err,
  output logic [NUM_CH*ERR_CNT_W-1:0] err_cnt,
  output logic                        err_any
);
  import pll_mon_pkg::*;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pll_lock_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .ERR_CNT_W     (ERR_CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_lock        (lock_in[g]),
      .i_start       (start),
      .i_clr_err     (clr_err),
      .o_locked      (locked[g]),
      .o_timeout_err (timeout_err[g]),
      .o_unlock_err  (unlock_err[g]),
      .o_err_cnt     (err_cnt[g*ERR_CNT_W +: ERR_CNT_W])
    );
  end

  assign all_locked = &locked;
  assign err_any    = (|timeout_err) || (|unlock_err);

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pll_lock_monitor                                                |
// | Scoreboard bench: expectations queued with stimulus, popped due.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pll_lock_monitor;

  localparam int NUM_CH = 2;
  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int TMO    = 64;
  localparam int CW     = 3;

  localparam int K_L0  = 0;
  localparam int K_L1  = 1;
  localparam int K_ALL = 2;
  localparam int K_TO  = 3;
  localparam int K_UL  = 4;
  localparam int K_C0  = 5;
  localparam int K_C1  = 6;
  localparam int K_ANY = 7;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH-1:0]      lock_in = '0;
  logic                   start = 1'b0;
  logic                   clr_err = 1'b0;
  logic [NUM_CH-1:0]      locked;
  logic                   all_locked;
  logic [NUM_CH-1:0]      timeout_err;
  logic [NUM_CH-1:0]      unlock_err;
  logic [NUM_CH*CW-1:0]   err_cnt;
  logic                   err_any;

  pll_lock_monitor #(
    .NUM_CH        (NUM_CH),
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT  (TMO),
    .ERR_CNT_W     (CW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lock_in     (lock_in),
    .start       (start),
    .clr_err     (clr_err),
    .locked      (locked),
    .all_locked  (all_locked),
    .timeout_err (timeout_err),
    .unlock_err  (unlock_err),
    .err_cnt     (err_cnt),
    .err_any     (err_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] obs(input int kind);
    case (kind)
      K_L0:    return {7'd0, locked[0]};
      K_L1:    return {7'd0, locked[1]};
      K_ALL:   return {7'd0, all_locked};
      K_TO:    return {6'd0, timeout_err};
      K_UL:    return {6'd0, unlock_err};
      K_C0:    return {5'd0, err_cnt[2:0]};
      K_C1:    return {5'd0, err_cnt[5:3]};
      default: return {7'd0, err_any};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, {24'd0, obs(sb[i].kind)}, {24'd0, sb[i].val});
        sb.delete(i);
      end
    end
  end

  task automatic push(input int due, input int kind, input logic [7:0] v, input string tag);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    wait_cyc(cyc + 1);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_cyc(cyc + 1);
    clr_err = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      chk("drain", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // One start/timeout round with both lock inputs low; checks ch0 count before and at timeout.
  task automatic tmo_round(input int prev, input int nxt, input string tag);
    int s;
    pulse_start(s);
    push(s + TMO - 1, K_C0, 8'(prev), {tag, "_pre"});
    push(s + TMO,     K_C0, 8'(nxt),  tag);
    wait_cyc(s + TMO);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int c;

    // Reset state
    #12;
    chk("rst_locked", locked, 0);
    chk("rst_all", all_locked, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_ul", unlock_err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_any", err_any, 0);
    #10 rst_n = 1'b1;
    wait_cyc(cyc + 3);

    // Basic lock and latency
    pulse_start(s);
    push(s + 28, K_L0,  0, "t1_l0_pre");
    push(s + 29, K_L0,  1, "t1_l0");
    push(s + 38, K_L1,  0, "t1_l1_pre");
    push(s + 39, K_L1,  1, "t1_l1");
    push(s + 38, K_ALL, 0, "t1_all_pre");
    push(s + 39, K_ALL, 1, "t1_all");
    push(s + 40, K_ANY, 0, "t1_noerr");
    push(s + 70, K_ANY, 0, "t1_noerr_late");
    push(s + 70, K_ALL, 1, "t1_all_late");
    wait_cyc(s + 10);
    lock_in[0] = 1'b1;
    wait_cyc(s + 20);
    lock_in[1] = 1'b1;
    wait_cyc(s + 71);
    drain();

    // Loss of lock on ch1
    c = cyc;
    lock_in[1] = 1'b0;
    push(c + 2, K_L1,  1, "t3_l1_pre");
    push(c + 3, K_L1,  0, "t3_l1");
    push(c + 3, K_ALL, 0, "t3_all");
    push(c + 3, K_UL,  8'b10, "t3_ul");
    push(c + 3, K_C1,  1, "t3_c1");
    push(c + 3, K_C0,  0, "t3_c0");
    push(c + 3, K_L0,  1, "t3_l0");
    push(c + 3, K_ANY, 1, "t3_any");
    wait_cyc(c + 5);
    drain();

    // clr_err alone
    c = cyc;
    push(c + 1, K_UL,  0, "t5b_ul");
    push(c + 1, K_C1,  0, "t5b_c1");
    push(c + 1, K_ANY, 0, "t5b_any");
    push(c + 1, K_L0,  1, "t5b_l0");
    pulse_clr();
    drain();

    // Glitch then timeout
    lock_in = '0;
    pulse_start(s);
    push(s + 10,      K_L0,  0, "t2_l0_a");
    push(s + 30,      K_L0,  0, "t2_l0_b");
    push(s + TMO - 1, K_TO,  0, "t2_to_pre");
    push(s + TMO,     K_TO,  8'b11, "t2_to");
    push(s + TMO,     K_C0,  1, "t2_c0");
    push(s + TMO,     K_C1,  1, "t2_c1");
    push(s + TMO,     K_UL,  0, "t2_ul");
    push(s + TMO,     K_ANY, 1, "t2_any");
    push(s + TMO,     K_L0,  0, "t2_l0_c");
    wait_cyc(s + 5);
    lock_in[0] = 1'b1;
    wait_cyc(s + 13);
    lock_in[0] = 1'b0;
    wait_cyc(s + TMO + 2);
    drain();

    // Counter saturation
    pulse_clr();
    for (int k = 1; k <= 9; k++) begin
      tmo_round((k - 1 > 7) ? 7 : k - 1, (k > 7) ? 7 : k, $sformatf("t4_r%0d", k));
    end
    chk("t4_c1_sat", err_cnt[5:3], 7);

    // clr_err coinciding with a timeout
    pulse_clr();
    for (int k = 1; k <= 5; k++) begin
      tmo_round(k - 1, k, $sformatf("t5_r%0d", k));
    end
    pulse_start(s);
    push(s + TMO - 1, K_C0, 5, "t5_c0_pre");
    push(s + TMO,     K_C0, 1, "t5_c0");
    push(s + TMO,     K_C1, 1, "t5_c1");
    push(s + TMO,     K_TO, 8'b11, "t5_to");
    wait_cyc(s + TMO - 1);
    clr_err = 1'b1;
    wait_cyc(s + TMO);
    clr_err = 1'b0;
    drain();
    c = cyc;
    push(c + 1, K_TO,  0, "t5_clr_to");
    push(c + 1, K_C0,  0, "t5_clr_c0");
    push(c + 1, K_ANY, 0, "t5_clr_any");
    pulse_clr();
    drain();

    // Reset mid-operation: ch0 LOCKED, ch1 STABLE, err_cnt=3
    for (int k = 1; k <= 3; k++) begin
      tmo_round(k - 1, k, $sformatf("t6_r%0d", k));
    end
    pulse_start(s);
    lock_in[0] = 1'b1;
    wait_cyc(s + 22);
    lock_in[1] = 1'b1;
    wait_cyc(s + 27);
    chk("t6_pre_l0", locked[0], 1);
    chk("t6_pre_c0", err_cnt[2:0], 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_all", all_locked, 0);
    chk("t6_rst_to", timeout_err, 0);
    chk("t6_rst_cnt", err_cnt, 0);
    chk("t6_rst_any", err_any, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_cyc(cyc + 40);
    chk("t6_nostart_locked", locked, 0);
    chk("t6_nostart_to", timeout_err, 0);
    pulse_start(s);
    push(s + 16, K_L0,  0, "t6_l0_pre");
    push(s + 17, K_L0,  1, "t6_l0");
    push(s + 17, K_ALL, 1, "t6_all");
    push(s + 17, K_C0,  0, "t6_c0");
    wait_cyc(s + 18);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
